// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-ported data memory between the CPU MEM stage and the UART loader.
// One access in flight at a time; CPU has priority, bounded by a loader starvation counter.
module data_mem_arbiter #(
  parameter int unsigned DATA_MEM_WIDTH = 3,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned MAX_CPU_BURST  = 4
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic                      cpu_ack,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_stall,
  input  logic                      ld_req,
  input  logic                      ld_we,
  input  logic [31:0]               ld_addr,
  input  logic [31:0]               ld_wdata,
  output logic                      ld_ack,
  output logic [31:0]               ld_rdata,
  output logic [DATA_MEM_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [31:0]               mem_rdata,
  output logic                      busy
);

  localparam int unsigned AW = DATA_MEM_WIDTH;
  localparam int unsigned CW = $clog2(MAX_CPU_BURST + 1);
  localparam int unsigned LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_CPU_BURST);
  localparam logic [LW-1:0] WAIT_INIT = LW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic [LW-1:0] wait_cnt;
  logic          cmd_ld;
  logic          cmd_we;

  logic          grant_ld_c;
  logic          accept_c;
  logic          sel_we_c;
  logic [31:0]   sel_addr_c;
  logic [31:0]   sel_wdata_c;
  logic          unused;

  // Loader wins when alone, or when the CPU has used up its burst allowance.
  assign grant_ld_c  = ld_req & (~cpu_req | (starve_cnt == BURST_MAX));
  assign accept_c    = (state == IDLE) & (cpu_req | ld_req);
  assign sel_we_c    = grant_ld_c ? ld_we    : cpu_we;
  assign sel_addr_c  = grant_ld_c ? ld_addr  : cpu_addr;
  assign sel_wdata_c = grant_ld_c ? ld_wdata : cpu_wdata;

  assign cpu_stall = cpu_req & ~cpu_ack;

  // Byte-lane bits and bits above the memory depth are intentionally dropped.
  assign unused = ^{cpu_addr[31:AW+2], cpu_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      cmd_ld     <= 1'b0;
      cmd_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cpu_ack   <= 1'b0;
      ld_ack    <= 1'b0;

      // Counts CPU grants won over a waiting loader; any gap in ld_req forgives them.
      if (!ld_req || (accept_c && grant_ld_c)) begin
        starve_cnt <= '0;
      end else if (accept_c && (starve_cnt != BURST_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            cmd_ld    <= grant_ld_c;
            cmd_we    <= sel_we_c;
            mem_addr  <= sel_addr_c[AW+1:2];
            mem_wdata <= sel_wdata_c;
            mem_we    <= sel_we_c;
            mem_re    <= ~sel_we_c;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_INIT;
          if (cmd_we) begin
            state   <= ACK;
            cpu_ack <= ~cmd_ld;
            ld_ack  <= cmd_ld;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= ACK;
            if (cmd_ld) begin
              ld_rdata <= mem_rdata;
              ld_ack   <= 1'b1;
            end else begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: a transaction-level timing/arbitration model
// plus a reference memory image predicts every output, every cycle.
module tb_data_mem_arbiter;

  localparam int unsigned AW    = 3;
  localparam int unsigned LAT   = 1;
  localparam int unsigned MAXB  = 4;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned NCYC  = 3000;

  logic          CLK;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          ld_req, ld_we, ld_ack;
  logic [31:0]   ld_addr, ld_wdata, ld_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_we, mem_re, busy;

  data_mem_arbiter #(
    .DATA_MEM_WIDTH(AW), .RD_LATENCY(LAT), .MAX_CPU_BURST(MAXB)
  ) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory behind the arbiter: written only by the DUT's strobes, read data after LAT cycles.
  logic        preload;
  logic [31:0] seed_mem [DEPTH];
  logic [31:0] mem_arr  [DEPTH];
  logic [31:0] rd_pipe  [LAT];

  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= seed_mem[i];
    end else if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= mem_re ? mem_arr[mem_addr] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int n_cmp, n_err, cyc, n_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state.
  bit          m_busy, m_we;
  int          m_own, m_acc, m_ack, starve, win;
  logic [AW-1:0] m_wa;
  logic [31:0] m_wd, m_exp_rd, sel_addr;
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [DEPTH];
  bit          ack_prev [2];
  bit          was_busy, issue, ackc, e_cack, e_lack, acc, hold, rst_req;

  // Requester state: 0 = CPU, 1 = loader.
  bit          r_act [2];
  bit          r_fly [2];
  bit          r_we  [2];
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];

  task automatic drive(input int i, input logic rq, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end else begin
      ld_req = rq; ld_we = we; ld_addr = a; ld_wdata = d;
    end
  endtask

  task automatic new_req(input int i);
    r_act[i]   = 1'b1;
    r_fly[i]   = 1'b0;
    r_we[i]    = 1'($urandom_range(0, 1));
    r_addr[i]  = $urandom;
    r_wdata[i] = $urandom;
    drive(i, 1'b1, r_we[i], r_addr[i], r_wdata[i]);
  endtask

  task automatic check_rst_outputs(input string tag);
    chk({tag, "_mem_re"},    32'(mem_re),    32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    chk({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
    chk({tag, "_ld_ack"},    32'(ld_ack),    32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata,      32'd0);
    chk({tag, "_ld_rdata"},  ld_rdata,       32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'(cpu_req));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; n_rst = 0;
    reset = 1'b1; preload = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      seed_mem[i] = $urandom;
      ref_mem[i]  = seed_mem[i];
    end
    for (int i = 0; i < 2; i++) begin
      exp_rd[i] = '0; ack_prev[i] = 1'b0; r_act[i] = 1'b0; r_fly[i] = 1'b0;
    end
    m_busy = 1'b0; starve = 0; rst_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    preload = 1'b0;
    check_rst_outputs("por");

    for (int n = 0; n < NCYC; n++) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (reset) reset = 1'b0;
      hold = (cyc >= 1500) && (cyc < 1800);
      if (cyc == 400 || cyc == 1100 || cyc == 2400) rst_req = 1'b1;

      // Asynchronous reset while a read is waiting for memory data.
      if (rst_req && m_busy && !m_we && (cyc > m_acc + 1) && (cyc < m_ack)) begin
        reset = 1'b1;
        #1;
        check_rst_outputs("mid_rst");
        rst_req = 1'b0;
        n_rst++;
        m_busy = 1'b0;
        starve = 0;
        for (int i = 0; i < 2; i++) begin
          exp_rd[i]   = '0;
          ack_prev[i] = 1'b0;
          if (r_fly[i]) begin
            r_fly[i] = 1'b0;
            drive(i, 1'b1, r_we[i], r_addr[i], r_wdata[i]);
          end
        end
      end

      for (int i = 0; i < 2; i++) begin
        if (ack_prev[i]) begin
          ack_prev[i] = 1'b0;
          r_act[i] = 1'b0;
          r_fly[i] = 1'b0;
          if (hold || $urandom_range(0, 3) == 0) new_req(i);
          else drive(i, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end else if (!r_act[i]) begin
          if (hold || $urandom_range(0, 99) < 30) new_req(i);
        end else if (r_fly[i] && !hold) begin
          // Accepted requests may wander or withdraw; the arbiter must ignore that.
          if ($urandom_range(0, 3) == 0)
            drive(i, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end

      @(negedge CLK);
      was_busy = m_busy;
      issue  = m_busy && (cyc == m_acc + 1);
      ackc   = m_busy && (cyc == m_ack);
      e_cack = ackc && (m_own == 0);
      e_lack = ackc && (m_own == 1);
      if (ackc && !m_we) exp_rd[m_own] = m_exp_rd;

      chk("mem_re",    32'(mem_re),    32'(issue && !m_we));
      chk("mem_we",    32'(mem_we),    32'(issue && m_we));
      chk("mem_addr",  32'(mem_addr),  issue ? 32'(m_wa) : 32'd0);
      chk("mem_wdata", mem_wdata,      issue ? m_wd : 32'd0);
      chk("cpu_ack",   32'(cpu_ack),   32'(e_cack));
      chk("ld_ack",    32'(ld_ack),    32'(e_lack));
      chk("cpu_rdata", cpu_rdata,      exp_rd[0]);
      chk("ld_rdata",  ld_rdata,       exp_rd[1]);
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cack));
      chk("busy",      32'(busy),      32'(m_busy && (cyc > m_acc)));

      if (ackc) begin
        ack_prev[m_own] = 1'b1;
        m_busy = 1'b0;
      end

      acc = !was_busy && !reset && (cpu_req || ld_req);
      if (cpu_req && ld_req) win = (starve == MAXB) ? 1 : 0;
      else                   win = ld_req ? 1 : 0;

      if (reset || !ld_req || (acc && win == 1)) starve = 0;
      else if (acc && starve < MAXB)             starve++;

      if (acc) begin
        m_busy   = 1'b1;
        m_own    = win;
        m_we     = (win == 1) ? ld_we    : cpu_we;
        sel_addr = (win == 1) ? ld_addr  : cpu_addr;
        m_wd     = (win == 1) ? ld_wdata : cpu_wdata;
        m_wa     = sel_addr[AW+1:2];
        m_acc    = cyc;
        m_ack    = cyc + 2 + (m_we ? 0 : LAT);
        if (m_we) ref_mem[m_wa] = m_wd;
        else      m_exp_rd = ref_mem[m_wa];
        r_fly[win] = 1'b1;
      end
    end

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (8) @(posedge CLK);
    #1;
    for (int i = 0; i < DEPTH; i++) chk("mem_final", mem_arr[i], ref_mem[i]);
    chk("busy_final", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
